// File: rtl/trigger_pkg.sv
// Shared constants, state encoding and slot helper for the trigger frame path.
package trigger_pkg;

    localparam logic [3:0] SLOT_FIRST = 4'd0;
    localparam logic [3:0] SLOT_LAST  = 4'd9;
    localparam logic       START_BIT  = 1'b0;
    localparam logic       STOP_BIT   = 1'b1;

    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h55;
    localparam logic [7:0] DEFAULT_TRIG_BYTE = 8'hA5;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    // Successor of a slot index; anything at or past the last slot wraps to slot 0.
    function automatic logic [3:0] next_slot(input logic [3:0] slot);
        return (slot >= SLOT_LAST) ? SLOT_FIRST : slot + 4'd1;
    endfunction

endpackage

// File: rtl/trigger_frame_tx_if.sv
// Bundle between the trigger FSM side and the frame transmitter.
// trig_count exists only when TRIGGER_FRAME_STATS_EN is defined.
interface trigger_frame_tx_if
`ifdef TRIGGER_FRAME_STATS_EN
    #(parameter int CNT_W = 16)
`endif
    ;

    logic [3:0] tx_counter;
    logic       is_trigger;
    logic       tx_line;
    logic       frame_start;
    logic       frame_done;
    logic       frame_is_trig;
    logic       sync_err;
`ifdef TRIGGER_FRAME_STATS_EN
    logic [CNT_W-1:0] trig_count;
`endif

    modport master (
        output tx_counter,
        output is_trigger,
`ifdef TRIGGER_FRAME_STATS_EN
        input  trig_count,
`endif
        input  tx_line,
        input  frame_start,
        input  frame_done,
        input  frame_is_trig,
        input  sync_err
    );

    modport slave (
        input  tx_counter,
        input  is_trigger,
`ifdef TRIGGER_FRAME_STATS_EN
        output trig_count,
`endif
        output tx_line,
        output frame_start,
        output frame_done,
        output frame_is_trig,
        output sync_err
    );

endinterface

// File: rtl/trigger_slot_check.sv
// Tracks the slot expected next and flags any sample that breaks the 0..9 sequence.
module trigger_slot_check
    import trigger_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] tx_counter_i,
    output logic       slot_err_o
);

    logic [3:0] exp_q;
    logic [3:0] exp_d;

    always_comb begin
        exp_d = next_slot(tx_counter_i);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exp_q <= SLOT_FIRST;
        end else begin
            exp_q <= exp_d;
        end
    end

    // Only meaningful while a frame is running; the caller gates it with its state.
    assign slot_err_o = (tx_counter_i > SLOT_LAST) || (tx_counter_i != exp_q);

endmodule

// File: rtl/trigger_frame_tx.sv
// 10-slot serial frame transmitter (start, 8 payload bits LSB first, stop) driven by the slot counter.
// Optional trigger-frame statistics counter enabled by TRIGGER_FRAME_STATS_EN.
module trigger_frame_tx
    import trigger_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = DEFAULT_IDLE_BYTE,
    parameter logic [7:0] TRIG_BYTE = DEFAULT_TRIG_BYTE,
    parameter int         CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    trigger_frame_tx_if.slave  bus
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_line_q, tx_line_d;
    logic       start_q, start_d;
    logic       done_q, done_d;
    logic       is_trig_q, is_trig_d;
    logic       err_q, err_d;
    logic       slot_err;
    logic       at_first;

    trigger_slot_check u_slot_check (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_counter_i (bus.tx_counter),
        .slot_err_o   (slot_err)
    );

    assign at_first = (bus.tx_counter == SLOT_FIRST);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        tx_line_d = STOP_BIT;
        start_d   = 1'b0;
        done_d    = 1'b0;
        is_trig_d = is_trig_q;
        err_d     = 1'b0;
        unique case (state_q)
            ST_SYNC: begin
                if (at_first) begin
                    state_d   = ST_RUN;
                    shift_d   = bus.is_trigger ? TRIG_BYTE : IDLE_BYTE;
                    is_trig_d = bus.is_trigger;
                    tx_line_d = START_BIT;
                    start_d   = 1'b1;
                end
            end
            ST_RUN: begin
                // A break in the sequence aborts the frame even if it lands on slot 0.
                if (slot_err) begin
                    state_d = ST_SYNC;
                    err_d   = 1'b1;
                end else if (at_first) begin
                    shift_d   = bus.is_trigger ? TRIG_BYTE : IDLE_BYTE;
                    is_trig_d = bus.is_trigger;
                    tx_line_d = START_BIT;
                    start_d   = 1'b1;
                end else if (bus.tx_counter == SLOT_LAST) begin
                    tx_line_d = STOP_BIT;
                    done_d    = 1'b1;
                end else begin
                    tx_line_d = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_SYNC;
            shift_q   <= 8'h00;
            tx_line_q <= STOP_BIT;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            is_trig_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            tx_line_q <= tx_line_d;
            start_q   <= start_d;
            done_q    <= done_d;
            is_trig_q <= is_trig_d;
            err_q     <= err_d;
        end
    end

    assign bus.tx_line       = tx_line_q;
    assign bus.frame_start   = start_q;
    assign bus.frame_done    = done_q;
    assign bus.frame_is_trig = is_trig_q;
    assign bus.sync_err      = err_q;

`ifdef TRIGGER_FRAME_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts with the frame_start it accompanies; saturates rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (start_d && is_trig_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.trig_count = cnt_q;
`endif

endmodule
